// File: rtl/i2c_mmio_pkg.sv
// Shared definitions for the I2C MMIO controller: command codes, status bits, register offsets.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package i2c_mmio_pkg;

    typedef enum logic [3:0] {
        CMD_NOP         = 4'h0,
        CMD_READ        = 4'h1,
        CMD_WRITE       = 4'h2,
        CMD_WRITE_MULTI = 4'h3,
        CMD_START       = 4'h4,
        CMD_STOP        = 4'h5,
        CMD_SET_ADDR    = 4'hB,
        CMD_RESET       = 4'hF
    } cmd_e;

    // Status register bit positions
    localparam int ST_READ_RDY   = 0;
    localparam int ST_WRITE_RDY  = 1;
    localparam int ST_BUSY       = 2;
    localparam int ST_INT        = 3;
    localparam int ST_MISSED_ACK = 9;

    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_STATUS   = 2'd1,
        REG_PRESCALE = 2'd2
    } reg_off_e;

    // Latched client request
    typedef struct packed {
        logic       write;
        logic [6:0] dev;
        logic [7:0] regi;
        logic [7:0] wdata;
    } req_t;

    // Command issued at a given step of the write or read list
    function automatic cmd_e step_cmd(input logic write, input logic [1:0] step);
        cmd_e c;
        c = CMD_NOP;
        case (step)
            2'd0: c = CMD_SET_ADDR;
            2'd1: if (write) c = CMD_WRITE_MULTI; else c = CMD_WRITE;
            2'd2: if (write) c = CMD_WRITE_MULTI; else c = CMD_READ;
            default: if (write) c = CMD_NOP; else c = CMD_STOP;
        endcase
        return c;
    endfunction

    // Full 16-bit command word: {3'b0, last, cmd, payload}
    function automatic logic [15:0] cmd_word(input req_t r, input logic [1:0] step);
        logic [7:0] payload;
        logic       last;
        payload = 8'h00;
        if (step == 2'd0)
            payload = {r.dev, 1'b0};
        else if (step == 2'd1)
            payload = r.regi;
        else if (step == 2'd2 && r.write)
            payload = r.wdata;
        last = r.write && (step == 2'd2);
        return {3'b000, last, step_cmd(r.write, step), payload};
    endfunction

    function automatic logic step_is_last(input logic write, input logic [1:0] step);
        return write ? (step == 2'd2) : (step == 2'd3);
    endfunction

    // Command finished: controller idle and the flag belonging to this command raised
    function automatic logic poll_done(input cmd_e c, input logic [3:0] st);
        logic hit;
        hit = 1'b0;
        case (c)
            CMD_WRITE, CMD_WRITE_MULTI: hit = st[ST_WRITE_RDY];
            CMD_READ:                   hit = st[ST_READ_RDY];
            CMD_STOP:                   hit = st[ST_INT];
            default:                    hit = 1'b0;
        endcase
        return hit && !st[ST_BUSY];
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// Client request/response and MMIO bus bundle for the I2C register sequencer.
// Latency: n/a (wiring only).
// Backpressure: client side is valid/ready; MMIO side is a strobe handshake.
interface i2c_reg_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [6:0]  req_dev;
    logic [7:0]  req_reg;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_error;
    logic [15:0] mmio_d;
    logic [15:0] mmio_q;
    logic [1:0]  mmio_addr;
    logic        mmio_i2c_select;
    logic        mmio_int_select;
    logic        mmio_req;
    logic        mmio_wr;

    // Sequencer side
    modport master (
        input  req_valid, req_write, req_dev, req_reg, req_wdata, mmio_q,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mmio_d, mmio_addr, mmio_i2c_select, mmio_int_select, mmio_req, mmio_wr
    );

    // Client plus controller side
    modport slave (
        output req_valid, req_write, req_dev, req_reg, req_wdata, mmio_q,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mmio_d, mmio_addr, mmio_i2c_select, mmio_int_select, mmio_req, mmio_wr
    );
endinterface

// File: rtl/i2c_mmio_access.sv
// Performs one MMIO access: holds mmio_req high REQ_HOLD cycles, captures mmio_q on the last high cycle.
// Latency: start cycle + REQ_HOLD high cycles + 1 low cycle (done pulses in the low cycle).
// Backpressure: start is ignored unless idle; caller holds start until done.
module i2c_mmio_access #(
    parameter int REQ_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic        i2c_sel,
    input  logic        int_sel,
    input  logic [1:0]  addr,
    input  logic [15:0] d,
    output logic        idle,
    output logic        done,
    output logic [15:0] q,
    output logic        mmio_req,
    output logic        mmio_wr,
    output logic        mmio_i2c_select,
    output logic        mmio_int_select,
    output logic [1:0]  mmio_addr,
    output logic [15:0] mmio_d,
    input  logic [15:0] mmio_q
);
    localparam logic [1:0] A_IDLE = 2'd0;
    localparam logic [1:0] A_HIGH = 2'd1;
    localparam logic [1:0] A_LOW  = 2'd2;

    localparam int         HOLD      = (REQ_HOLD < 1) ? 1 : REQ_HOLD;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    logic [1:0] state;
    logic [7:0] hold_cnt;

    // Strobe sequencing: latch bus fields, hold req high, then force one low cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= A_IDLE;
            hold_cnt        <= 8'd0;
            q               <= 16'h0000;
            mmio_req        <= 1'b0;
            mmio_wr         <= 1'b0;
            mmio_i2c_select <= 1'b0;
            mmio_int_select <= 1'b0;
            mmio_addr       <= 2'd0;
            mmio_d          <= 16'h0000;
        end else begin
            case (state)
                A_IDLE: begin
                    if (start) begin
                        mmio_req        <= 1'b1;
                        mmio_wr         <= wr;
                        mmio_i2c_select <= i2c_sel;
                        mmio_int_select <= int_sel;
                        mmio_addr       <= addr;
                        mmio_d          <= d;
                        hold_cnt        <= 8'd0;
                        state           <= A_HIGH;
                    end
                end
                A_HIGH: begin
                    if (hold_cnt == HOLD_LAST) begin
                        mmio_req <= 1'b0;
                        q        <= mmio_q;
                        state    <= A_LOW;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                A_LOW: begin
                    mmio_i2c_select <= 1'b0;
                    mmio_int_select <= 1'b0;
                    state           <= A_IDLE;
                end
                default: state <= A_IDLE;
            endcase
        end
    end

    assign idle = (state == A_IDLE);
    assign done = (state == A_LOW);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write request into the I2C MMIO command sequence, polling status until done.
// Latency: several MMIO accesses plus status polls; resp_valid pulses once per accepted request.
// Backpressure: req_ready low while a request is in flight; req_valid during that time is ignored.
module i2c_reg_sequencer
    import i2c_mmio_pkg::*;
#(
    parameter int POLL_GAP = 8,
    parameter int REQ_HOLD = 2,
    parameter int TIMEOUT  = 65535
) (
    input logic                   clk,
    input logic                   rst,
    i2c_reg_sequencer_if.master   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_FETCH = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [15:0] GAP     = 16'(POLL_GAP);
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

    logic [2:0]  state;
    logic [1:0]  step;
    req_t        req_r;
    logic [15:0] gap_cnt;
    logic [15:0] tmo_cnt;
    logic        req_ready;
    logic [7:0]  resp_rdata;
    logic        resp_error;

    logic        acc_start;
    logic        acc_wr;
    logic        acc_i2c;
    logic        acc_int;
    logic [1:0]  acc_addr;
    logic [15:0] acc_d;
    logic        acc_idle;
    logic        acc_done;
    logic [15:0] acc_q;

    cmd_e        cur_cmd;
    logic        tmo_hit;
    logic        unused_q_bits;

    assign cur_cmd       = step_cmd(req_r.write, step);
    assign tmo_hit       = (tmo_cnt >= TMO_LIM);
    assign unused_q_bits = ^{acc_q[15:10], acc_q[8]};

    // Bus access requested by the current state
    always_comb begin
        acc_start = 1'b0;
        acc_wr    = 1'b0;
        acc_i2c   = 1'b1;
        acc_int   = 1'b0;
        acc_addr  = REG_DATA;
        acc_d     = 16'h0000;
        case (state)
            S_CLEAR: begin
                acc_start = 1'b1;
                acc_i2c   = 1'b0;
                acc_int   = 1'b1;
            end
            S_ISSUE: begin
                acc_start = 1'b1;
                acc_wr    = 1'b1;
                acc_d     = cmd_word(req_r, step);
            end
            S_POLL: begin
                // Never launch a poll once timed out, so abort cannot collide with a live access
                acc_start = (gap_cnt == 16'd0) && !tmo_hit;
                acc_addr  = REG_STATUS;
            end
            S_FETCH: begin
                acc_start = 1'b1;
            end
            S_ABORT: begin
                acc_start = 1'b1;
                acc_wr    = 1'b1;
                acc_d     = {4'h0, CMD_STOP, 8'h00};
            end
            default: ;
        endcase
    end

    i2c_mmio_access #(.REQ_HOLD(REQ_HOLD)) u_access (
        .clk             (clk),
        .rst             (rst),
        .start           (acc_start),
        .wr              (acc_wr),
        .i2c_sel         (acc_i2c),
        .int_sel         (acc_int),
        .addr            (acc_addr),
        .d               (acc_d),
        .idle            (acc_idle),
        .done            (acc_done),
        .q               (acc_q),
        .mmio_req        (bus.mmio_req),
        .mmio_wr         (bus.mmio_wr),
        .mmio_i2c_select (bus.mmio_i2c_select),
        .mmio_int_select (bus.mmio_int_select),
        .mmio_addr       (bus.mmio_addr),
        .mmio_d          (bus.mmio_d),
        .mmio_q          (bus.mmio_q)
    );

    // Sequencer FSM: step through the command list, poll, fetch, abort on error
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            step       <= 2'd0;
            req_r      <= '0;
            gap_cnt    <= 16'd0;
            tmo_cnt    <= 16'd0;
            req_ready  <= 1'b1;
            resp_rdata <= 8'h00;
            resp_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_ready) begin
                        req_r      <= '{write: bus.req_write, dev: bus.req_dev,
                                        regi: bus.req_reg, wdata: bus.req_wdata};
                        req_ready  <= 1'b0;
                        step       <= 2'd0;
                        resp_rdata <= 8'h00;
                        resp_error <= 1'b0;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    tmo_cnt <= 16'd0;
                    if (acc_done)
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (acc_done) begin
                        gap_cnt <= 16'd0;
                        state   <= (cur_cmd == CMD_SET_ADDR) ? S_NEXT : S_POLL;
                    end
                end
                S_POLL: begin
                    if (!tmo_hit)
                        tmo_cnt <= tmo_cnt + 16'd1;
                    if (gap_cnt != 16'd0)
                        gap_cnt <= gap_cnt - 16'd1;
                    if (acc_done) begin
                        if (acc_q[ST_MISSED_ACK])
                            state <= S_ABORT;
                        else if (poll_done(cur_cmd, acc_q[3:0]))
                            state <= S_NEXT;
                        else if (tmo_hit)
                            state <= S_ABORT;
                        else
                            gap_cnt <= GAP;
                    end else if (acc_idle && tmo_hit) begin
                        state <= S_ABORT;
                    end
                end
                S_NEXT: begin
                    if (cur_cmd == CMD_READ) begin
                        state <= S_FETCH;
                    end else if (step_is_last(req_r.write, step)) begin
                        state <= S_DONE;
                    end else begin
                        step  <= step + 2'd1;
                        state <= S_CLEAR;
                    end
                end
                S_FETCH: begin
                    if (acc_done) begin
                        resp_rdata <= acc_q[7:0];
                        step       <= step + 2'd1;
                        state      <= S_CLEAR;
                    end
                end
                S_ABORT: begin
                    if (acc_done) begin
                        resp_error <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state == S_DONE);
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_error = resp_error;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural MMIO controller, vector table plus corner-case sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_reg_sequencer;
    localparam int REQ_HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_reg_sequencer_if bus();

    i2c_reg_sequencer #(.POLL_GAP(8), .REQ_HOLD(REQ_HOLD), .TIMEOUT(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Controller model configuration
    logic        stuck     = 1'b0;
    logic [15:0] nack_word = 16'hFFFF;
    logic [7:0]  rbyte     = 8'h00;

    // Controller model state
    logic [15:0] wlog[$];
    logic        prev_req;
    int          busy_cnt;
    logic [3:0]  pend;
    logic [15:0] pend_word;
    logic        f_rr, f_wr, f_int, f_miss;
    logic [7:0]  dat;

    // Controller: log command words, run a short busy period, raise the matching flag
    always @(posedge clk) begin
        if (rst) begin
            prev_req <= 1'b0;
            busy_cnt <= 0;
            pend     <= 4'h0;
            pend_word<= 16'h0;
            f_rr <= 1'b0; f_wr <= 1'b0; f_int <= 1'b0; f_miss <= 1'b0;
            dat  <= 8'h00;
        end else begin
            prev_req <= bus.mmio_req;
            if (bus.mmio_req && !prev_req) begin
                if (bus.mmio_int_select) begin
                    f_rr <= 1'b0; f_wr <= 1'b0; f_int <= 1'b0; f_miss <= 1'b0;
                end else if (bus.mmio_i2c_select && bus.mmio_wr && bus.mmio_addr == 2'd0) begin
                    wlog.push_back(bus.mmio_d);
                    pend      <= bus.mmio_d[11:8];
                    pend_word <= bus.mmio_d;
                    busy_cnt  <= 3;
                end
            end else if (busy_cnt > 0 && !stuck) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    case (pend)
                        4'h2, 4'h3: if (pend_word == nack_word) f_miss <= 1'b1; else f_wr <= 1'b1;
                        4'h1: begin f_rr <= 1'b1; dat <= rbyte; end
                        4'h5: f_int <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.mmio_q = (bus.mmio_addr == 2'd1)
                      ? {6'b0, f_miss, 5'b0, f_int, (busy_cnt != 0), f_wr, f_rr}
                      : {8'h00, dat};

    // Strobe width monitor
    int run = 0, hold_bad = 0, n_acc = 0;
    always @(negedge clk) begin
        if (rst) run <= 0;
        else if (bus.mmio_req) run <= run + 1;
        else if (run != 0) begin
            if (run != REQ_HOLD) hold_bad <= hold_bad + 1;
            n_acc <= n_acc + 1;
            run   <= 0;
        end
    end

    typedef struct {
        logic             w;
        logic [6:0]       dev;
        logic [7:0]       rg;
        logic [7:0]       wd;
        logic [7:0]       rb;
        logic [15:0]      nack;
        int               n;
        logic [3:0][15:0] words;
        logic [7:0]       exp_rd;
        logic             exp_err;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wd, input logic [7:0] rb, input logic [15:0] nack,
                                input int n, input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [7:0] erd, input logic eerr);
        vec_t v;
        v.w = w; v.dev = dev; v.rg = rg; v.wd = wd; v.rb = rb; v.nack = nack; v.n = n;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
        v.exp_rd = erd; v.exp_err = eerr;
        return v;
    endfunction

    function automatic logic [15:0] word_at(input int idx);
        if (idx < wlog.size()) return wlog[idx];
        return 16'hDEAD;
    endfunction

    task automatic send(input logic w, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_dev   = dev;
        bus.req_reg   = rg;
        bus.req_wdata = wd;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic got, output logic [7:0] rd, output logic er,
                             output int width, output int cyc);
        got = 1'b0; rd = 8'h00; er = 1'b0; width = 0; cyc = 0;
        while (!got && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_valid) begin
                got = 1'b1;
                rd  = bus.resp_rdata;
                er  = bus.resp_error;
            end
        end
        if (got) begin
            width = 1;
            @(negedge clk);
            while (bus.resp_valid && width < 10) begin
                width++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         base, width, cyc;
        logic       got, er;
        logic [7:0] rd;
        nack_word = v.nack;
        rbyte     = v.rb;
        base      = wlog.size();
        send(v.w, v.dev, v.rg, v.wd);
        check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        wait_resp(got, rd, er, width, cyc);
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        check({tag, "_nwords"}, 32'(wlog.size() - base), 32'(v.n));
        for (int i = 0; i < v.n; i++)
            check($sformatf("%s_word%0d", tag, i), 32'(word_at(base + i)), 32'(v.words[i]));
        check({tag, "_rdata"}, 32'(rd), 32'(v.exp_rd));
        check({tag, "_error"}, 32'(er), 32'(v.exp_err));
        check({tag, "_pulse_width"}, 32'(width), 32'd1);
        check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rdata_hold"}, 32'(bus.resp_rdata), 32'(v.exp_rd));
        nack_word = 16'hFFFF;
    endtask

    vec_t vecs[6];

    initial begin
        int         base, width, cyc, n;
        logic       got, er;
        logic [7:0] rd;

        vecs[0] = mk(1'b1, 7'h50, 8'h10, 8'hA5, 8'h00, 16'hFFFF, 3,
                     16'h0BA0, 16'h0310, 16'h13A5, 16'h0000, 8'h00, 1'b0);
        vecs[1] = mk(1'b0, 7'h68, 8'h00, 8'h00, 8'h3C, 16'hFFFF, 4,
                     16'h0BD0, 16'h0200, 16'h0100, 16'h0500, 8'h3C, 1'b0);
        vecs[2] = mk(1'b1, 7'h50, 8'h10, 8'hA5, 8'h00, 16'h0310, 3,
                     16'h0BA0, 16'h0310, 16'h0500, 16'h0000, 8'h00, 1'b1);
        vecs[3] = mk(1'b0, 7'h23, 8'h7F, 8'h00, 8'hC5, 16'hFFFF, 4,
                     16'h0B46, 16'h027F, 16'h0100, 16'h0500, 8'hC5, 1'b0);
        vecs[4] = mk(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h00, 16'hFFFF, 3,
                     16'h0BFE, 16'h03FF, 16'h1300, 16'h0000, 8'h00, 1'b0);
        vecs[5] = mk(1'b0, 7'h11, 8'h11, 8'h00, 8'h99, 16'h0211, 3,
                     16'h0B22, 16'h0211, 16'h0500, 16'h0000, 8'h00, 1'b1);

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_dev   = 7'h00;
        bus.req_reg   = 8'h00;
        bus.req_wdata = 8'h00;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(bus.req_ready),       32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid),      32'd0);
        check("rst_resp_rdata", 32'(bus.resp_rdata),      32'd0);
        check("rst_resp_error", 32'(bus.resp_error),      32'd0);
        check("rst_mmio_req",   32'(bus.mmio_req),        32'd0);
        check("rst_i2c_sel",    32'(bus.mmio_i2c_select), 32'd0);
        check("rst_int_sel",    32'(bus.mmio_int_select), 32'd0);
        check("rst_mmio_d",     32'(bus.mmio_d),          32'd0);
        check("rst_mmio_addr",  32'(bus.mmio_addr),       32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Vector table
        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Busy status stuck: timeout abort
        stuck = 1'b1;
        base  = wlog.size();
        send(1'b1, 7'h50, 8'h10, 8'hA5);
        wait_resp(got, rd, er, width, cyc);
        check("tmo_resp_seen", 32'(got), 32'd1);
        check("tmo_error",     32'(er),  32'd1);
        check("tmo_nwords",    32'(wlog.size() - base), 32'd3);
        check("tmo_word2",     32'(word_at(base + 2)), 32'h0500);
        check("tmo_not_early", 32'(cyc >= 110), 32'd1);
        check("tmo_not_late",  32'(cyc <= 140), 32'd1);
        check("tmo_ready_back", 32'(bus.req_ready), 32'd1);
        stuck = 1'b0;
        repeat (5) @(negedge clk);

        // Reset while polling
        stuck = 1'b1;
        base  = wlog.size();
        send(1'b1, 7'h50, 8'h10, 8'hA5);
        n = 0;
        while (wlog.size() < base + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rstpoll_reached", 32'(wlog.size() >= base + 2), 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstpoll_mmio_req",   32'(bus.mmio_req),   32'd0);
        check("rstpoll_req_ready",  32'(bus.req_ready),  32'd1);
        check("rstpoll_resp_valid", 32'(bus.resp_valid), 32'd0);
        rst   = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check("rstpoll_no_stop", 32'(wlog.size() - base), 32'd2);
        run_vec(vecs[1], "after_rst");

        // Second request while busy is dropped
        base = wlog.size();
        send(1'b1, 7'h50, 8'h10, 8'hA5);
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_dev   = 7'h01;
        bus.req_reg   = 8'hEE;
        repeat (10) @(negedge clk);
        bus.req_valid = 1'b0;
        wait_resp(got, rd, er, width, cyc);
        check("ign_resp_seen", 32'(got), 32'd1);
        check("ign_error",     32'(er),  32'd0);
        check("ign_word0",     32'(word_at(base)),     32'h0BA0);
        check("ign_word1",     32'(word_at(base + 1)), 32'h0310);
        check("ign_word2",     32'(word_at(base + 2)), 32'h13A5);
        repeat (40) @(negedge clk);
        check("ign_no_extra",  32'(wlog.size() - base), 32'd3);

        // Strobe timing over the whole run
        check("strobe_width_violations", 32'(hold_bad), 32'd0);
        check("strobe_accesses_seen",    32'(n_acc > 20), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Hardware master for the I2C MMIO controller: turns one register-level request (device, register, data) into the full MMIO command sequence, polls status until done, and returns read data or an error.
- Sits between on-chip clients (RTC/config fetchers) and the I2C MMIO controller's bus port, so hardware can access I2C slaves without the host CPU.

Parameters:
- POLL_GAP, 8, idle cycles between successive status polls
- REQ_HOLD, 2, cycles mmio_req is held high per access (min 1); always followed by 1 low cycle
- TIMEOUT, 65535, max poll cycles per command before aborting with error

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  client request present
- req_ready  out  1  sequencer idle, request accepted when valid&ready
- req_write  in  1  1=register write, 0=register read
- req_dev  in  7  7-bit slave address
- req_reg  in  8  register index
- req_wdata  in  8  write payload
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  8  read byte (0 for writes)
- resp_error  out  1  missed ACK or timeout; qualified by resp_valid
- mmio_d  out  16  command word to controller (bits 12,11:8,7:0 = last, cmd, payload)
- mmio_q  in  16  controller read data
- mmio_addr  out  2  register select (addr[3:2])
- mmio_i2c_select  out  1  controller select
- mmio_int_select  out  1  status-flag clear select
- mmio_req  out  1  access strobe (controller acts on rising edge)
- mmio_wr  out  1  1=write access

Behaviour:
- Reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mmio_req=0, all selects=0, mmio_d=0, mmio_addr=0, state IDLE. Reset mid-sequence aborts immediately; no STOP is issued.
- Command list (cmd code, payload, last):
  - Write: SET_ADDR(0xB, dev<<1), WRITE_MULTI(0x3, reg, 0), WRITE_MULTI(0x3, wdata, 1).
  - Read: SET_ADDR, WRITE(0x2, reg), READ(0x1), STOP(0x5).
- Step counter (2 bits) indexes the list.
- Access: drive select/addr/wr/d, mmio_req high for REQ_HOLD cycles, then low ≥1 cycle. For reads, mmio_q is sampled on the last high cycle.
- FSM:
  - IDLE: on valid&ready, latch request, req_ready<=0, step=0 -> CLEAR.
  - CLEAR: read access with mmio_int_select=1 (clears flags) -> ISSUE.
  - ISSUE: write command word for the current step. SET_ADDR goes straight to NEXT; others go to POLL.
  - POLL: every POLL_GAP cycles, read status (addr 01).
    - Done when q[2] busy=0 and the required flag is set: bit1 for WRITE/WRITE_MULTI, bit0 for READ, q[3] for STOP.
    - q[9] missed_ack=1 -> ABORT.
    - Poll-cycle counter reaching TIMEOUT -> ABORT.
  - NEXT: if the step was READ -> FETCH; if last step -> DONE; else step+1 -> CLEAR.
  - FETCH: read addr 00, resp_rdata<=q[7:0] -> NEXT path (step+1).
  - ABORT: issue STOP command (no poll), resp_error<=1 -> DONE.
  - DONE: resp_valid=1 for one cycle, req_ready<=1 next cycle -> IDLE.
- resp_rdata/resp_error hold until next request accepted.
- req_valid while busy is ignored (no queue).
- Timeout counter is 16 bits, reset on each CLEAR.

Decomposition:
- Shared package i2c_mmio_pkg:
  - command codes CMD_NOP..CMD_RESET
  - status bit positions (READ_RDY=0, WRITE_RDY=1, BUSY=2, INT=3, MISSED_ACK=9)
  - register offsets (DATA=0, STATUS=1, PRESCALE=2)
- Sub-module: i2c_mmio_access — handles one MMIO access (strobe timing, REQ_HOLD, q capture) with start/done handshake; the sequencer FSM uses it for every bus access.

Test Plan:
- Write dev=0x50 reg=0x10 data=0xA5, model ACKs -> command words 0x0BA0, 0x0310, 0x13A5 issued in order; resp_valid with error=0.
- Read dev=0x68 reg=0x00, model returns 0x3C -> words 0x0BD0, 0x0200, 0x0100, 0x0500 issued; resp_rdata=0x3C, error=0.
- Missed ACK (status q[9]=1) on the register byte -> STOP 0x0500 issued, resp_error=1, no further WRITE_MULTI.
- Busy stuck high with TIMEOUT=100 -> abort after ~100 poll cycles, resp_error=1, req_ready returns to 1.
- rst asserted during POLL -> next cycle mmio_req=0, req_ready=1; a following request completes normally.
- Every access: mmio_req high exactly REQ_HOLD cycles with ≥1 low cycle between accesses; second req_valid while busy is ignored.
